// File: rtl/lcd_pixel_serializer.sv
// Game Boy pixel serializer: takes tile-row bitplane pairs over a valid/ready
// handshake, shifts out one palette-shaded pixel per clock during the active
// part of each line, and generates the line/pixel counters, write strobe and
// hsync/vsync framing used by the downstream LCD double-buffer converter.
module lcd_pixel_serializer #(
    parameter int LINE_WIDTH    = 160,
    parameter int FRAME_LINES   = 144,
    parameter int HBLANK_CYCLES = 296,
    parameter int VBLANK_LINES  = 10,
    parameter int LINE_PERIOD   = 456
) (
    input  logic       gb_clock,
    input  logic       gb_clock_rst_b,
    input  logic       lcd_enable,
    input  logic [7:0] tile_lo,
    input  logic [7:0] tile_hi,
    input  logic       tile_valid,
    output logic       tile_ready,
    input  logic [7:0] bgp,
    output logic [1:0] pixel_data,
    output logic [7:0] gb_pixel_count,
    output logic [7:0] gb_line_count,
    output logic       gb_we,
    output logic       gb_hsync,
    output logic       gb_vsync,
    output logic       underflow
);

    localparam int VBLANK_CYCLES = VBLANK_LINES * LINE_PERIOD;
    localparam int PHASE_W       = $clog2(LINE_PERIOD);

    localparam logic [12:0]        BLANK_MAX   = 13'h1FFF;
    localparam logic [12:0]        HBLANK_LAST = 13'(HBLANK_CYCLES - 1);
    localparam logic [12:0]        VBLANK_LAST = 13'(VBLANK_CYCLES - 1);
    localparam logic [PHASE_W-1:0] PHASE_LAST  = PHASE_W'(LINE_PERIOD - 1);
    localparam logic [7:0]         X_LAST      = 8'(LINE_WIDTH - 1);
    localparam logic [7:0]         Y_LAST      = 8'(FRAME_LINES - 1);
    localparam logic [7:0]         Y_VBLANK    = 8'(FRAME_LINES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        VBLANK = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [7:0]          hold_lo_reg, hold_lo_next;
    logic [7:0]          hold_hi_reg, hold_hi_next;
    logic                hold_full_reg, hold_full_next;
    logic [7:0]          shift_lo_reg, shift_lo_next;
    logic [7:0]          shift_hi_reg, shift_hi_next;
    logic [3:0]          pix_left_reg, pix_left_next;
    logic [7:0]          x_reg, x_next;
    logic [7:0]          y_reg, y_next;
    logic [12:0]         blank_cnt_reg, blank_cnt_next;
    logic [PHASE_W-1:0]  phase_reg, phase_next;
    logic [1:0]          pixel_reg, pixel_next;
    logic [7:0]          pixel_count_reg, pixel_count_next;
    logic                we_reg, we_next;
    logic                hsync_reg, hsync_next;
    logic                vsync_reg, vsync_next;
    logic                underflow_reg, underflow_next;

    logic                accept;
    logic                load;
    logic [1:0]          pix_idx;
    logic [1:0]          shade;
    logic [12:0]         blank_inc;

    // Ready is held low while in reset so nothing is offered as accepted.
    assign tile_ready = gb_clock_rst_b & lcd_enable & ~hold_full_reg;
    assign accept     = tile_valid & tile_ready;

    // Leftmost pixel of the shift register and its palette shade.
    assign pix_idx = {shift_hi_reg[7], shift_lo_reg[7]};
    assign shade   = bgp[{pix_idx, 1'b0} +: 2];

    // Blank counter saturates instead of wrapping.
    assign blank_inc = (blank_cnt_reg == BLANK_MAX) ? blank_cnt_reg : blank_cnt_reg + 13'd1;

    assign pixel_data     = pixel_reg;
    assign gb_pixel_count = pixel_count_reg;
    assign gb_line_count  = y_reg;
    assign gb_we          = we_reg;
    assign gb_hsync       = hsync_reg;
    assign gb_vsync       = vsync_reg;
    assign underflow      = underflow_reg;

    // Next-state, datapath and output decode; lcd_enable low overrides everything.
    always_comb begin
        state_next       = state_reg;
        hold_lo_next     = hold_lo_reg;
        hold_hi_next     = hold_hi_reg;
        hold_full_next   = hold_full_reg;
        shift_lo_next    = shift_lo_reg;
        shift_hi_next    = shift_hi_reg;
        pix_left_next    = pix_left_reg;
        x_next           = x_reg;
        y_next           = y_reg;
        blank_cnt_next   = blank_cnt_reg;
        phase_next       = phase_reg;
        pixel_next       = pixel_reg;
        pixel_count_next = pixel_count_reg;
        we_next          = 1'b0;
        hsync_next       = hsync_reg;
        vsync_next       = vsync_reg;
        underflow_next   = underflow_reg;
        load             = 1'b0;

        case (state_reg)
            IDLE: begin
                // Loading on the start edge keeps first-pixel latency at two edges.
                if (hold_full_reg) begin
                    state_next = ACTIVE;
                    x_next     = 8'd0;
                    y_next     = 8'd0;
                    load       = 1'b1;
                end
            end
            ACTIVE: begin
                if (pix_left_reg != 4'd0) begin
                    pixel_next       = shade;
                    we_next          = 1'b1;
                    pixel_count_next = x_reg;
                    shift_lo_next    = {shift_lo_reg[6:0], 1'b0};
                    shift_hi_next    = {shift_hi_reg[6:0], 1'b0};
                    pix_left_next    = pix_left_reg - 4'd1;
                    // Refill on the last pixel so back-to-back tiles have no bubble.
                    if (pix_left_reg == 4'd1 && hold_full_reg) begin
                        load = 1'b1;
                    end
                    if (x_reg == X_LAST) begin
                        state_next     = HBLANK;
                        x_next         = 8'd0;
                        blank_cnt_next = 13'd0;
                        hsync_next     = 1'b1;
                    end else begin
                        x_next = x_reg + 8'd1;
                    end
                end else if (hold_full_reg) begin
                    load = 1'b1;
                end else begin
                    underflow_next = 1'b1;
                end
            end
            HBLANK: begin
                if (blank_cnt_reg == HBLANK_LAST) begin
                    hsync_next = 1'b0;
                    if (y_reg == Y_LAST) begin
                        state_next     = VBLANK;
                        vsync_next     = 1'b1;
                        y_next         = Y_VBLANK;
                        blank_cnt_next = 13'd0;
                        phase_next     = '0;
                    end else begin
                        state_next = ACTIVE;
                        y_next     = y_reg + 8'd1;
                    end
                end else begin
                    blank_cnt_next = blank_inc;
                end
            end
            VBLANK: begin
                if (blank_cnt_reg == VBLANK_LAST) begin
                    vsync_next = 1'b0;
                    y_next     = 8'd0;
                    state_next = ACTIVE;
                end else begin
                    blank_cnt_next = blank_inc;
                    if (phase_reg == PHASE_LAST) begin
                        phase_next = '0;
                        y_next     = y_reg + 8'd1;
                    end else begin
                        phase_next = phase_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (load) begin
            shift_lo_next  = hold_lo_reg;
            shift_hi_next  = hold_hi_reg;
            pix_left_next  = 4'd8;
            hold_full_next = 1'b0;
        end

        // A same-edge accept refills the hold register behind a load.
        if (accept) begin
            hold_lo_next   = tile_lo;
            hold_hi_next   = tile_hi;
            hold_full_next = 1'b1;
        end

        if (!lcd_enable) begin
            state_next       = IDLE;
            hold_lo_next     = 8'd0;
            hold_hi_next     = 8'd0;
            hold_full_next   = 1'b0;
            shift_lo_next    = 8'd0;
            shift_hi_next    = 8'd0;
            pix_left_next    = 4'd0;
            x_next           = 8'd0;
            y_next           = 8'd0;
            blank_cnt_next   = 13'd0;
            phase_next       = '0;
            pixel_next       = 2'd0;
            pixel_count_next = 8'd0;
            we_next          = 1'b0;
            hsync_next       = 1'b0;
            vsync_next       = 1'b0;
            underflow_next   = 1'b0;
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge gb_clock or negedge gb_clock_rst_b) begin
        if (!gb_clock_rst_b) begin
            state_reg       <= IDLE;
            hold_lo_reg     <= 8'd0;
            hold_hi_reg     <= 8'd0;
            hold_full_reg   <= 1'b0;
            shift_lo_reg    <= 8'd0;
            shift_hi_reg    <= 8'd0;
            pix_left_reg    <= 4'd0;
            x_reg           <= 8'd0;
            y_reg           <= 8'd0;
            blank_cnt_reg   <= 13'd0;
            phase_reg       <= '0;
            pixel_reg       <= 2'd0;
            pixel_count_reg <= 8'd0;
            we_reg          <= 1'b0;
            hsync_reg       <= 1'b0;
            vsync_reg       <= 1'b0;
            underflow_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            hold_lo_reg     <= hold_lo_next;
            hold_hi_reg     <= hold_hi_next;
            hold_full_reg   <= hold_full_next;
            shift_lo_reg    <= shift_lo_next;
            shift_hi_reg    <= shift_hi_next;
            pix_left_reg    <= pix_left_next;
            x_reg           <= x_next;
            y_reg           <= y_next;
            blank_cnt_reg   <= blank_cnt_next;
            phase_reg       <= phase_next;
            pixel_reg       <= pixel_next;
            pixel_count_reg <= pixel_count_next;
            we_reg          <= we_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            underflow_reg   <= underflow_next;
        end
    end

endmodule

// File: tb/tb_lcd_pixel_serializer.sv
// Bench for lcd_pixel_serializer: a queue-based reference model predicts every
// output each cycle, a palette vector table checks shading and first-pixel
// latency, and directed sequences cover framing, stall, disable and reset.
module tb_lcd_pixel_serializer;

    localparam int W   = 160;
    localparam int FL  = 144;
    localparam int HB  = 296;
    localparam int VBL = 10;
    localparam int LP  = 456;

    localparam int M_IDLE = 0;
    localparam int M_ACT  = 1;
    localparam int M_HB   = 2;
    localparam int M_VB   = 3;

    logic       gb_clock = 1'b0;
    logic       gb_clock_rst_b;
    logic       lcd_enable;
    logic [7:0] tile_lo, tile_hi, bgp;
    logic       tile_valid;
    logic       tile_ready;
    logic [1:0] pixel_data;
    logic [7:0] gb_pixel_count, gb_line_count;
    logic       gb_we, gb_hsync, gb_vsync, underflow;

    lcd_pixel_serializer #(
        .LINE_WIDTH(W), .FRAME_LINES(FL), .HBLANK_CYCLES(HB),
        .VBLANK_LINES(VBL), .LINE_PERIOD(LP)
    ) dut (
        .gb_clock(gb_clock), .gb_clock_rst_b(gb_clock_rst_b), .lcd_enable(lcd_enable),
        .tile_lo(tile_lo), .tile_hi(tile_hi), .tile_valid(tile_valid), .tile_ready(tile_ready),
        .bgp(bgp), .pixel_data(pixel_data), .gb_pixel_count(gb_pixel_count),
        .gb_line_count(gb_line_count), .gb_we(gb_we), .gb_hsync(gb_hsync),
        .gb_vsync(gb_vsync), .underflow(underflow)
    );

    always #5 gb_clock = ~gb_clock;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: pending tiles and remaining pixels of the current tile as queues.
    logic [15:0] m_tiles[$];
    logic [1:0]  m_cur[$];
    int          m_mode, m_x, m_y, m_timer, m_pc;
    logic [1:0]  m_pix;
    logic        m_we, m_hs, m_vs, m_uf;

    // Frame statistics observed from DUT outputs.
    bit stats_on = 0;
    int we_line, hs_len, vs_len, hs_falls, vs_rises, vs_falls;
    logic prev_hs = 1'b0, prev_vs = 1'b0;

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [7:0]  pal;
        logic [15:0] exp_pix;
    } vec_t;
    vec_t vecs[5];

    task automatic finish_up();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    task automatic check(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at t=%0t got %0h want %0h", name, $time, got, want);
        end
    endtask

    task automatic timeout(string what);
        checks++;
        errors++;
        $display("FAIL timeout %s got no event want event", what);
        finish_up();
    endtask

    function automatic bit m_ready();
        return gb_clock_rst_b && lcd_enable && (m_tiles.size() == 0);
    endfunction

    task automatic model_clear();
        m_mode = M_IDLE; m_x = 0; m_y = 0; m_timer = 0; m_pc = 0;
        m_pix = 2'd0; m_we = 0; m_hs = 0; m_vs = 0; m_uf = 0;
        m_tiles.delete();
        m_cur.delete();
    endtask

    task automatic start_tile();
        logic [15:0] t;
        t = m_tiles.pop_front();
        m_cur.delete();
        for (int i = 7; i >= 0; i--) m_cur.push_back({t[8+i], t[i]});
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit acc;
        logic [1:0] idx;
        if (!gb_clock_rst_b || !lcd_enable) begin
            model_clear();
            return;
        end
        acc  = tile_valid && (m_tiles.size() == 0);
        m_we = 0;
        case (m_mode)
            M_IDLE: if (m_tiles.size() != 0) begin
                m_mode = M_ACT; m_x = 0; m_y = 0;
                start_tile();
            end
            M_ACT: begin
                if (m_cur.size() != 0) begin
                    idx   = m_cur.pop_front();
                    m_pix = 2'((bgp >> (2 * idx)) & 8'h03);
                    m_we  = 1;
                    m_pc  = m_x;
                    if (m_cur.size() == 0 && m_tiles.size() != 0) start_tile();
                    if (m_x == W - 1) begin
                        m_mode = M_HB; m_x = 0; m_timer = 0; m_hs = 1;
                    end else begin
                        m_x++;
                    end
                end else if (m_tiles.size() != 0) begin
                    start_tile();
                end else begin
                    m_uf = 1;
                end
            end
            M_HB: begin
                m_timer++;
                if (m_timer == HB) begin
                    m_hs = 0;
                    m_y++;
                    if (m_y == FL) begin
                        m_mode = M_VB; m_vs = 1; m_timer = 0;
                    end else begin
                        m_mode = M_ACT;
                    end
                end
            end
            default: begin
                m_timer++;
                if (m_timer == VBL * LP) begin
                    m_vs = 0; m_y = 0; m_mode = M_ACT;
                end else begin
                    m_y = FL + m_timer / LP;
                end
            end
        endcase
        if (acc) m_tiles.push_back({tile_hi, tile_lo});
    endtask

    task automatic monitor();
        if (gb_we) we_line++;
        if (gb_hsync) hs_len++;
        if (gb_vsync) vs_len++;
        if (gb_hsync && !prev_hs) begin
            check("line_we_count", we_line, W);
            we_line = 0;
        end
        if (!gb_hsync && prev_hs) begin
            check("hsync_len", hs_len, HB);
            hs_len = 0;
            hs_falls++;
        end
        if (gb_vsync && !prev_vs) begin
            check("vsync_line", gb_line_count, FL);
            vs_rises++;
        end
        if (!gb_vsync && prev_vs) begin
            check("vsync_len", vs_len, VBL * LP);
            vs_len = 0;
            vs_falls++;
        end
        prev_hs = gb_hsync;
        prev_vs = gb_vsync;
    endtask

    // One clock: step the model, sample 1 time unit after the edge, compare.
    task automatic tick();
        logic [22:0] got, want;
        model_step();
        @(posedge gb_clock);
        #1;
        cyc++;
        want = {m_ready(), m_pix, 8'(m_pc), 8'(m_y), m_we, m_hs, m_vs, m_uf};
        got  = {tile_ready, pixel_data, gb_pixel_count, gb_line_count,
                gb_we, gb_hsync, gb_vsync, underflow};
        check("cycle_outputs", got, want);
        if (stats_on) monitor();
        if (errors > 30) finish_up();
    endtask

    task automatic rand_tile();
        tile_lo = 8'($urandom);
        tile_hi = 8'($urandom);
        bgp     = 8'($urandom);
    endtask

    initial begin
        logic [15:0] got_pix;
        int lat, n, gap, held, gap_done, bound;

        vecs[0] = '{lo: 8'hFF, hi: 8'h00, pal: 8'hE4, exp_pix: 16'h5555};
        vecs[1] = '{lo: 8'h0F, hi: 8'h33, pal: 8'h1B, exp_pix: 16'hF5A0};
        vecs[2] = '{lo: 8'hAA, hi: 8'hCC, pal: 8'hE4, exp_pix: 16'hE4E4};
        vecs[3] = '{lo: 8'h00, hi: 8'hFF, pal: 8'h6C, exp_pix: 16'hAAAA};
        vecs[4] = '{lo: 8'h81, hi: 8'h01, pal: 8'hD2, exp_pix: 16'h2AAB};

        model_clear();
        gb_clock_rst_b = 1'b0;
        lcd_enable     = 1'b1;
        tile_valid     = 1'b1;
        tile_lo = 8'hFF; tile_hi = 8'h00; bgp = 8'hE4;
        #12;
        check("reset_outputs", {tile_ready, pixel_data, gb_pixel_count, gb_line_count,
                                gb_we, gb_hsync, gb_vsync, underflow}, 0);
        tile_valid     = 1'b0;
        lcd_enable     = 1'b0;
        gb_clock_rst_b = 1'b1;

        // Palette / bit-order vectors, each from a freshly enabled serializer.
        for (int v = 0; v < 5; v++) begin
            lcd_enable = 1'b0; tile_valid = 1'b0;
            tick();
            lcd_enable = 1'b1;
            tile_lo = vecs[v].lo; tile_hi = vecs[v].hi; bgp = vecs[v].pal;
            tile_valid = 1'b1;
            tick();
            tile_valid = 1'b0;
            lat = 0; n = 0; got_pix = 16'd0;
            for (int c = 1; c <= 12; c++) begin
                tick();
                if (gb_we) begin
                    if (n == 0) lat = c;
                    got_pix = {got_pix[13:0], pixel_data};
                    n++;
                end
            end
            $display("vector %0d lo %h hi %h bgp %h pixels %h latency %0d",
                     v, vecs[v].lo, vecs[v].hi, vecs[v].pal, got_pix, lat);
            check("first_we_latency", lat, 2);
            check("pixel_count_per_tile", n, 8);
            check("shaded_pixels", got_pix, vecs[v].exp_pix);
        end

        // Continuous tiles, then drop lcd_enable at x=80 while a tile is offered.
        lcd_enable = 1'b0; tile_valid = 1'b0;
        tick();
        lcd_enable = 1'b1; tile_valid = 1'b1;
        bound = 0;
        while (!(m_mode == M_ACT && m_y == 3 && m_x == 80 && m_tiles.size() == 0)) begin
            if (++bound > 5000) timeout("reach_x80");
            rand_tile();
            tick();
        end
        lcd_enable = 1'b0;
        tick();
        check("disable_clear", {tile_ready, pixel_data, gb_pixel_count, gb_line_count,
                                gb_we, gb_hsync, gb_vsync, underflow}, 0);

        // Full frame after re-enable, with framing statistics.
        stats_on = 1; we_line = 0; hs_len = 0; vs_len = 0;
        hs_falls = 0; vs_rises = 0; vs_falls = 0;
        prev_hs = 1'b0; prev_vs = 1'b0;
        lcd_enable = 1'b1;
        bound = 0;
        do begin
            if (++bound > 10) timeout("restart_we");
            rand_tile();
            tick();
        end while (!gb_we);
        check("restart_xy", {gb_pixel_count, gb_line_count}, 0);
        bound = 0;
        while (vs_falls == 0) begin
            if (++bound > 80000) timeout("frame_end");
            rand_tile();
            tick();
        end
        check("hsync_per_frame", hs_falls, FL);
        check("vsync_rises", vs_rises, 1);
        check("line_after_vblank", gb_line_count, 0);
        stats_on = 0;

        // Starve the serializer for 12 cycles right after a refill at x=32.
        bound = 0;
        while (!(m_mode == M_ACT && m_y == 0 && m_x == 32 && m_tiles.size() == 0)) begin
            if (++bound > 2000) timeout("reach_x32");
            rand_tile();
            tick();
        end
        gap = 0; held = 0; gap_done = 0;
        for (int c = 0; c < 30; c++) begin
            tile_valid = (c >= 12);
            rand_tile();
            tick();
            if (!gap_done) begin
                if (!gb_we) begin
                    gap++;
                    held = gb_pixel_count;
                end else if (gap > 0) begin
                    gap_done = 1;
                end
            end
        end
        check("stall_gap", gap, 6);
        check("stall_held_x", held, 39);
        check("underflow_set", underflow, 1);

        // Random valid pattern and palettes.
        for (int c = 0; c < 2500; c++) begin
            tile_valid = ($urandom_range(3) != 0);
            rand_tile();
            tick();
        end
        check("underflow_sticky", underflow, 1);

        // Asynchronous reset in the middle of HBLANK.
        tile_valid = 1'b1;
        bound = 0;
        while (!(m_mode == M_HB && m_timer == 100)) begin
            if (++bound > 5000) timeout("reach_hblank");
            rand_tile();
            tick();
        end
        #2;
        gb_clock_rst_b = 1'b0;
        #1;
        check("async_reset_clear", {tile_ready, pixel_data, gb_pixel_count, gb_line_count,
                                    gb_we, gb_hsync, gb_vsync, underflow}, 0);
        for (int c = 0; c < 3; c++) tick();
        gb_clock_rst_b = 1'b1;
        tile_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (gb_we) n++;
        end
        check("no_we_without_tile", n, 0);
        tile_valid = 1'b1;
        rand_tile();
        tick();
        tile_valid = 1'b0;
        n = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (gb_we) n++;
        end
        check("we_after_restart_tile", n, 8);

        finish_up();
    end

endmodule
